// File: rtl/wishbone_if.sv
// Single-master/single-slave Wishbone signal bundle.
// data_in carries master write data, data_out carries slave read data.
interface wishbone_if;
    logic        cycle;
    logic        strobe;
    logic [3:0]  select;
    logic [31:0] address;
    logic        write_enable;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (
        output cycle, strobe, select, address, write_enable, data_in,
        input  data_out, ack
    );

    modport slave (
        input  cycle, strobe, select, address, write_enable, data_in,
        output data_out, ack
    );
endinterface

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between instruction fetch (port 0) and
// load/store (port 1), with a watchdog that force-terminates unacknowledged accesses.
module wishbone_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    wishbone_if.slave   ifetch_bus,
    wishbone_if.slave   data_bus,
    wishbone_if.master  mem_bus,
    output logic [1:0]  o_grant,
    output logic        o_bus_timeout
);

    localparam int unsigned CntWidth =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TIMEOUT_CYCLES);
    localparam bit WatchdogOn = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy0 = 2'd1,
        StBusy1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [CntWidth-1:0] wd_cnt_q, wd_cnt_d;

    logic req0, req1;
    logic busy;
    logic owner_cycle, owner_strobe;
    logic expire;

    assign req0 = ifetch_bus.cycle & ifetch_bus.strobe;
    assign req1 = data_bus.cycle & data_bus.strobe;
    assign busy = (state_q == StBusy0) || (state_q == StBusy1);

    assign owner_cycle  = (state_q == StBusy1) ? data_bus.cycle  : ifetch_bus.cycle;
    assign owner_strobe = (state_q == StBusy1) ? data_bus.strobe : ifetch_bus.strobe;

    // A genuine slave ack in the expiry cycle takes precedence over the watchdog.
    assign expire = WatchdogOn && busy && (wd_cnt_q == CntLimit) && !mem_bus.ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = last_grant_q ? StBusy0 : StBusy1;
                end else if (req0) begin
                    state_d = StBusy0;
                end else if (req1) begin
                    state_d = StBusy1;
                end
            end
            StBusy0: begin
                if (expire || !ifetch_bus.cycle) begin
                    state_d      = StIdle;
                    last_grant_d = 1'b0;
                end
            end
            StBusy1: begin
                if (expire || !data_bus.cycle) begin
                    state_d      = StIdle;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter is zero on every entry to a busy state because it is cleared on exit.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (!busy || state_d == StIdle) begin
            wd_cnt_d = '0;
        end else if (mem_bus.ack) begin
            wd_cnt_d = '0;
        end else if (owner_strobe && WatchdogOn) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_comb begin
        o_grant              = 2'b00;
        o_bus_timeout        = 1'b0;
        mem_bus.cycle        = 1'b0;
        mem_bus.strobe       = 1'b0;
        mem_bus.select       = 4'b0000;
        mem_bus.address      = 32'h0;
        mem_bus.write_enable = 1'b0;
        mem_bus.data_in      = 32'h0;
        ifetch_bus.ack       = 1'b0;
        data_bus.ack         = 1'b0;
        ifetch_bus.data_out  = mem_bus.data_out;
        data_bus.data_out    = mem_bus.data_out;
        unique case (state_q)
            StBusy0: begin
                o_grant              = 2'b01;
                o_bus_timeout        = expire;
                mem_bus.cycle        = owner_cycle & ~expire;
                mem_bus.strobe       = owner_strobe & ~expire;
                mem_bus.select       = ifetch_bus.select;
                mem_bus.address      = ifetch_bus.address;
                mem_bus.write_enable = ifetch_bus.write_enable;
                mem_bus.data_in      = ifetch_bus.data_in;
                ifetch_bus.ack       = mem_bus.ack | expire;
                if (expire) begin
                    ifetch_bus.data_out = 32'h0;
                end
            end
            StBusy1: begin
                o_grant              = 2'b10;
                o_bus_timeout        = expire;
                mem_bus.cycle        = owner_cycle & ~expire;
                mem_bus.strobe       = owner_strobe & ~expire;
                mem_bus.select       = data_bus.select;
                mem_bus.address      = data_bus.address;
                mem_bus.write_enable = data_bus.write_enable;
                mem_bus.data_in      = data_bus.data_in;
                data_bus.ack         = mem_bus.ack | expire;
                if (expire) begin
                    data_bus.data_out = 32'h0;
                end
            end
            default: ;
        endcase
    end

endmodule
